position_encoder: RTL and testbench
===================================

// Module: position_encoder
// PURPOSE
//  Converts the 9-key board keypad into a 4-bit position code, one code per key press.
//  Code k means position k+1, so code 0 is position 1 and code 8 is position 9.
//  Steps per press: synchronise, debounce, check the press is legal, offer the code on a
//  valid/ready handshake. The game controller consumes the code.
// PARAMETERS
//  NUM_POS          9  number of keys/positions; must be <= 2**CODE_W
//  CODE_W           4  width of pos_code
//  DEBOUNCE_CYCLES  4  consecutive stable cycles required on press and on release (>=1)
// PORTS
//  clock         in   1        single clock, rising edge
//  reset         in   1        synchronous, active-high
//  btn           in   NUM_POS  raw asynchronous key levels, bit i = position i+1
//  occupied      in   NUM_POS  board-occupied mask; used only with OCCUPIED_CHECK_EN
//  pos_code      out  CODE_W   encoded position, stable while pos_valid
//  pos_valid     out  1        code offered
//  pos_ready     in   1        consumer accepts; transfer on pos_valid & pos_ready
//  err_multi     out  1        1-cycle pulse: more than one key was held at the check
//  err_occupied  out  1        1-cycle pulse: pressed position is occupied
// BEHAVIOUR
//  - Reset: state IDLE; btn_s, snapshot, counter, pos_code, pos_valid, err_* all 0.
//    Reset takes effect on the same edge in any state and drops pos_valid.
//  - btn passes through a 2-flop synchroniser to give btn_s.
//  - IDLE: btn_s!=0 -> DEBOUNCE; snapshot<=btn_s; cnt<=0.
//  - DEBOUNCE:
//      btn_s!=snapshot -> snapshot<=btn_s, cnt<=0.
//      If the new btn_s==0 -> IDLE.
//      Stable and cnt==DEBOUNCE_CYCLES-1 -> CHECK; otherwise cnt++.
//  - CHECK (1 cycle):
//      popcount(snapshot)!=1 -> err_multi=1 for this cycle; -> WAIT_REL.
//      Else, occupied check enabled and occupied[idx] -> err_occupied=1; -> WAIT_REL.
//      Else pos_code<=idx; pos_valid<=1; -> OFFER.
//  - OFFER:
//      pos_valid and pos_code held until pos_ready=1.
//      On transfer: pos_valid<=0; -> WAIT_REL.
//      Key release or new keys never withdraw an offer.
//  - WAIT_REL:
//      btn_s==0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE.
//      Any nonzero btn_s restarts the count.
//  - Latency: a level first sampled at edge 0 gives pos_valid=1 after edge DEBOUNCE_CYCLES+3
//    (7 with defaults), provided the key is stable throughout.
//  - pos_code takes only values 0..NUM_POS-1; it keeps its last value when pos_valid=0.
//  - Simultaneous events: a release in the same cycle as the transfer is counted toward
//    WAIT_REL from the next cycle.
//  - A key still held after reset is detected again as a new press.
// CONFIGURATION
//  OCCUPIED_CHECK_EN defined: CHECK rejects occupied positions as described above.
//  Undefined: occupied is ignored, err_occupied is tied to 0, and any single key is offered.
// STRUCTURE
//  - Package tictac_pkg: state enum (IDLE, DEBOUNCE, CHECK, OFFER, WAIT_REL),
//    NUM_POS_DEF=9, CODE_W_DEF=4.
//  - Sub-module btn_sync: NUM_POS-wide 2-flop synchroniser with synchronous reset.
//  - One-hot-to-index conversion and popcount are done inline.
// TESTING
//  1. Reset; btn=9'h010 held 12 cycles; pos_ready=1
//     -> pos_valid for exactly 1 cycle after edge 7; pos_code=4.
//  2. btn=9'h001; pos_ready=0 for 20 cycles, key released meanwhile
//     -> pos_valid and pos_code=0 held; exactly one transfer when ready rises; then IDLE.
//  3. btn=9'h005
//     -> err_multi pulses once; no pos_valid; no new event until all keys released 4 cycles.
//  4. btn toggles 9'h002/0 every 2 cycles for 10 cycles, then stays high
//     -> exactly one transfer, pos_code=1.
//  5. occupied=9'h100, btn=9'h100
//     -> with OCCUPIED_CHECK_EN: err_occupied pulse, no valid.
//     -> without it: pos_code=8 offered.
//  6. reset pulsed during OFFER with key still held
//     -> pos_valid=0 after that edge; the press is re-detected and offered again 7 edges
//        after reset is released.

Source files
------------

// File: rtl/tictac_pkg.sv
// Shared definitions for the keypad position encoder.
//   NUM_POS_DEF : default number of keys / board positions
//   CODE_W_DEF  : default width of the position code
//   state_t     : encoder controller states
package tictac_pkg;

    localparam int NUM_POS_DEF = 9;
    localparam int CODE_W_DEF  = 4;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        CHECK,
        OFFER,
        WAIT_REL
    } state_t;

endpackage

// File: rtl/position_encoder_btn_sync.sv
// Multi-bit two-flop synchroniser for the raw keypad levels.
// Each bit is an independent slow level, so per-bit synchronisation is
// sufficient; the debouncer downstream absorbs any skew between bits.
//   clock : sampling clock, rising edge
//   reset : synchronous, active-high; clears both stages
//   d     : asynchronous key levels
//   q     : synchronised key levels
module btn_sync #(
    parameter int WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/position_encoder.sv
// Keypad position encoder: turns one debounced, legal key press into a
// position code offered on a valid/ready handshake.
//   clock        : rising-edge clock
//   reset        : synchronous, active-high
//   btn          : raw key levels, bit i = position i+1
//   occupied     : board-occupied mask (only used with OCCUPIED_CHECK_EN)
//   pos_code     : position code 0..NUM_POS-1, stable while pos_valid
//   pos_valid    : code offered
//   pos_ready    : consumer accepts; transfer on pos_valid & pos_ready
//   err_multi    : 1-cycle pulse, more than one key held at the check
//   err_occupied : 1-cycle pulse, pressed position already occupied
// Build option: define OCCUPIED_CHECK_EN to reject presses on occupied
// positions; otherwise occupied is ignored and err_occupied stays 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no key seen, waiting for any nonzero synchronised level
// DEBOUNCE | counting consecutive cycles of an unchanged key pattern
// CHECK    | one cycle: validate the snapshot, raise error or offer
// OFFER    | code held on pos_code/pos_valid until pos_ready
// WAIT_REL | waiting for all keys released for DEBOUNCE_CYCLES cycles
module position_encoder
    import tictac_pkg::*;
#(
    parameter int NUM_POS         = NUM_POS_DEF,
    parameter int CODE_W          = CODE_W_DEF,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_POS-1:0] btn,
    input  logic [NUM_POS-1:0] occupied,
    output logic [CODE_W-1:0]  pos_code,
    output logic               pos_valid,
    input  logic               pos_ready,
    output logic               err_multi,
    output logic               err_occupied
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int POP_W = $clog2(NUM_POS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t             state, state_nxt;
    logic [NUM_POS-1:0] btn_s;
    logic [NUM_POS-1:0] snapshot, snap_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CODE_W-1:0]  code_nxt;
    logic               valid_nxt;
    logic [CODE_W-1:0]  idx;
    logic [POP_W-1:0]   pop_cnt;
    logic               occ_hit;

    btn_sync #(.WIDTH(NUM_POS)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (btn),
        .q     (btn_s)
    );

    // idx is only meaningful when exactly one snapshot bit is set
    always_comb begin
        idx     = '0;
        pop_cnt = '0;
        for (int i = 0; i < NUM_POS; i++) begin
            if (snapshot[i]) begin
                idx     = CODE_W'(i);
                pop_cnt = pop_cnt + 1'b1;
            end
        end
    end

`ifdef OCCUPIED_CHECK_EN
    // With a single key set, any overlap means that key's position is taken
    assign occ_hit = |(occupied & snapshot);
`else
    logic unused_occupied;
    assign unused_occupied = ^occupied;
    assign occ_hit         = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            snapshot  <= '0;
            cnt       <= '0;
            pos_code  <= '0;
            pos_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            snapshot  <= snap_nxt;
            cnt       <= cnt_nxt;
            pos_code  <= code_nxt;
            pos_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        snap_nxt     = snapshot;
        cnt_nxt      = cnt;
        code_nxt     = pos_code;
        valid_nxt    = pos_valid;
        err_multi    = 1'b0;
        err_occupied = 1'b0;

        case (state)
            IDLE: begin
                if (btn_s != '0) begin
                    state_nxt = DEBOUNCE;
                    snap_nxt  = btn_s;
                    cnt_nxt   = '0;
                end
            end
            DEBOUNCE: begin
                if (btn_s != snapshot) begin
                    snap_nxt = btn_s;
                    cnt_nxt  = '0;
                    if (btn_s == '0) state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = CHECK;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            CHECK: begin
                state_nxt = WAIT_REL;
                cnt_nxt   = '0;
                if (pop_cnt != POP_W'(1)) begin
                    err_multi = 1'b1;
                end else if (occ_hit) begin
                    err_occupied = 1'b1;
                end else begin
                    code_nxt  = idx;
                    valid_nxt = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                // key activity is deliberately ignored until the code is taken
                if (pos_ready) begin
                    valid_nxt = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (btn_s != '0) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_position_encoder.sv
module tb_position_encoder;

    localparam int NUM_POS = 9;
    localparam int CODE_W  = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NUM_POS-1:0] btn = '0;
    logic [NUM_POS-1:0] occupied = '0;
    logic               pos_ready = 1'b0;
    logic [CODE_W-1:0]  pos_code;
    logic               pos_valid;
    logic               err_multi;
    logic               err_occupied;

    always #5 clock = ~clock;

    position_encoder #(
        .NUM_POS         (NUM_POS),
        .CODE_W          (CODE_W),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .btn          (btn),
        .occupied     (occupied),
        .pos_code     (pos_code),
        .pos_valid    (pos_valid),
        .pos_ready    (pos_ready),
        .err_multi    (err_multi),
        .err_occupied (err_occupied)
    );

    int checks = 0;
    int errors = 0;

    // event monitor, sampled on the falling edge
    int                n_xfer = 0;
    int                n_em = 0;
    int                n_eo = 0;
    int                mon_bad = 0;
    logic [CODE_W-1:0] last_code = '0;
    bit                hold_en = 1'b0;
    logic              prev_v = 1'b0;
    logic              prev_r = 1'b0;
    logic [CODE_W-1:0] prev_code = '0;

    always @(negedge clock) begin
        if (pos_valid && pos_ready) begin
            n_xfer++;
            last_code = pos_code;
        end
        if (err_multi) n_em++;
        if (err_occupied) n_eo++;
        if (pos_valid && (int'(pos_code) >= NUM_POS)) begin
            mon_bad++;
            $display("FAIL code_range: got %0d, need < %0d", pos_code, NUM_POS);
        end
        if (hold_en && prev_v && !prev_r && (!pos_valid || pos_code !== prev_code)) begin
            mon_bad++;
            $display("FAIL offer_hold: got valid=%0b code=%0d, need valid=1 code=%0d",
                     pos_valid, pos_code, prev_code);
        end
        prev_v    = pos_valid;
        prev_r    = pos_ready;
        prev_code = pos_code;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [NUM_POS-1:0] btn;
        logic [NUM_POS-1:0] occ;
        int                 hold;
        int                 xfer;
        logic [CODE_W-1:0]  code;
        int                 em;
        int                 eo;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int b_x, b_m, b_o;

        vecs[0] = '{9'h001, 9'h000, 12, 1, 4'd0, 0, 0};
        vecs[1] = '{9'h010, 9'h000, 12, 1, 4'd4, 0, 0};
        vecs[2] = '{9'h100, 9'h000, 12, 1, 4'd8, 0, 0};
        vecs[3] = '{9'h005, 9'h000, 12, 0, 4'd0, 1, 0};
        vecs[4] = '{9'h180, 9'h000, 12, 0, 4'd0, 1, 0};
        vecs[5] = '{9'h1FF, 9'h000, 12, 0, 4'd0, 1, 0};
        vecs[6] = '{9'h020, 9'h1DF, 12, 1, 4'd5, 0, 0};
`ifdef OCCUPIED_CHECK_EN
        vecs[7] = '{9'h100, 9'h100, 12, 0, 4'd0, 0, 1};
`else
        vecs[7] = '{9'h100, 9'h100, 12, 1, 4'd8, 0, 0};
`endif
        vecs[8] = '{9'h008, 9'h000, 4, 0, 4'd0, 0, 0};
        vecs[9] = '{9'h008, 9'h000, 5, 1, 4'd3, 0, 0};

        // reset state, with keys and ready active during reset
        btn       = 9'h1FF;
        pos_ready = 1'b1;
        tick(4);
        check("rst_valid", pos_valid, 0);
        check("rst_code", pos_code, 0);
        check("rst_err_multi", err_multi, 0);
        check("rst_err_occ", err_occupied, 0);

        // 1: latency and single-cycle transfer
        reset   = 1'b0;
        btn     = 9'h010;
        hold_en = 1'b1;
        b_x     = n_xfer;
        tick(7);
        check("t1_valid_e6", pos_valid, 0);
        tick(1);
        check("t1_valid_e7", pos_valid, 1);
        check("t1_code", pos_code, 4);
        tick(1);
        check("t1_valid_e8", pos_valid, 0);
        tick(3);
        btn = '0;
        tick(12);
        check("t1_xfer", n_xfer - b_x, 1);

        // table of single presses with ready held high
        for (int i = 0; i < 10; i++) begin
            b_x = n_xfer;
            b_m = n_em;
            b_o = n_eo;
            occupied = vecs[i].occ;
            btn      = vecs[i].btn;
            tick(vecs[i].hold);
            btn = '0;
            tick(14);
            occupied = '0;
            check($sformatf("vec%0d_xfer", i), n_xfer - b_x, vecs[i].xfer);
            check($sformatf("vec%0d_err_multi", i), n_em - b_m, vecs[i].em);
            check($sformatf("vec%0d_err_occ", i), n_eo - b_o, vecs[i].eo);
            if (vecs[i].xfer != 0)
                check($sformatf("vec%0d_code", i), last_code, vecs[i].code);
        end

        // 2: offer held across release while ready is low
        b_x       = n_xfer;
        pos_ready = 1'b0;
        btn       = 9'h001;
        tick(10);
        btn = '0;
        tick(10);
        check("t2_valid_held", pos_valid, 1);
        check("t2_code_held", pos_code, 0);
        check("t2_no_xfer_yet", n_xfer - b_x, 0);
        pos_ready = 1'b1;
        tick(1);
        check("t2_valid_drop", pos_valid, 0);
        tick(12);
        check("t2_xfer", n_xfer - b_x, 1);

        // 3: two keys, then release too short before the next press
        b_x = n_xfer;
        b_m = n_em;
        btn = 9'h005;
        tick(10);
        check("t3_err_multi", n_em - b_m, 1);
        check("t3_no_valid", pos_valid, 0);
        btn = '0;
        tick(3);
        btn = 9'h002;
        tick(15);
        check("t3_short_rel_xfer", n_xfer - b_x, 0);
        check("t3_short_rel_err", n_em - b_m, 1);
        btn = '0;
        tick(4);
        btn = 9'h002;
        tick(15);
        check("t3_full_rel_xfer", n_xfer - b_x, 1);
        check("t3_full_rel_code", last_code, 1);
        btn = '0;
        tick(12);

        // 4: bouncing key settles high
        b_x = n_xfer;
        b_m = n_em;
        for (int i = 0; i < 5; i++) begin
            btn = (i % 2 == 0) ? 9'h002 : 9'h000;
            tick(2);
        end
        btn = 9'h002;
        tick(12);
        btn = '0;
        tick(12);
        check("t4_xfer", n_xfer - b_x, 1);
        check("t4_code", last_code, 1);
        check("t4_err_multi", n_em - b_m, 0);

        // 6: reset during an offer with the key still held
        b_x       = n_xfer;
        pos_ready = 1'b0;
        btn       = 9'h040;
        tick(8);
        check("t6_offer", pos_valid, 1);
        check("t6_offer_code", pos_code, 6);
        hold_en = 1'b0;
        reset   = 1'b1;
        tick(1);
        check("t6_rst_drop", pos_valid, 0);
        reset = 1'b0;
        tick(7);
        check("t6_redetect_e7", pos_valid, 0);
        tick(1);
        check("t6_redetect_e8", pos_valid, 1);
        check("t6_redetect_code", pos_code, 6);
        hold_en   = 1'b1;
        pos_ready = 1'b1;
        tick(1);
        check("t6_xfer_drop", pos_valid, 0);
        btn = '0;
        tick(12);
        check("t6_xfer", n_xfer - b_x, 1);

        check("monitor_violations", mon_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
